// File: rtl/stack_mem_ctrl.sv
// Byte-serial arbiter/sequencer sharing a 1 KiB data memory between LW/SW and PUSH/POP.
// Optional build macro MISALIGN_TRAP_EN traps unaligned load/store accesses in CHECK.
module stack_mem_ctrl #(
    parameter int ADDR_W     = 10,
    parameter int SP_INIT    = 1023,
    parameter int STACK_BASE = 768
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [31:0]       ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_done,
    output logic [31:0]       ls_rdata,
    output logic              ls_err,
    input  logic              stk_req,
    input  logic              stk_pop,
    input  logic [31:0]       stk_wdata,
    output logic              stk_done,
    output logic [31:0]       stk_rdata,
    output logic              stk_err,
    output logic [ADDR_W-1:0] sp_out,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata
);

    localparam int W1 = ADDR_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        WR,
        RD,
        RD_TAIL,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] sp;
    logic [ADDR_W-1:0] base;
    logic [31:0]       data;
    logic [23:0]       rbuf;
    logic [1:0]        beat;
    logic              gnt_stk;
    logic              op_wr;
    logic              err;
    logic              last_stk;

    logic pick_stk;
    logic ovf;
    logic unf;
    logic stk_fault;
    logic ls_fault;
    logic fault;
    logic unused_addr;

    assign unused_addr = ^ls_addr[31:ADDR_W];

    // Ties go to whoever did not win the previous tie.
    assign pick_stk = stk_req & (~ls_req | ~last_stk);

    assign ovf = {1'b0, sp} < W1'(STACK_BASE + 4);
    assign unf = ({1'b0, sp} + W1'(4)) > W1'(SP_INIT);
    assign stk_fault = gnt_stk & (op_wr ? ovf : unf);

`ifdef MISALIGN_TRAP_EN
    assign ls_fault = ~gnt_stk & (base[1:0] != 2'b00);
`else
    assign ls_fault = 1'b0;
`endif

    assign fault = stk_fault | ls_fault;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (ls_req || stk_req) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (fault) begin
                    state_nxt = DONE;
                end else if (op_wr) begin
                    state_nxt = WR;
                end else begin
                    state_nxt = RD;
                end
            end
            WR: begin
                if (beat == 2'd3) begin
                    state_nxt = DONE;
                end
            end
            RD: begin
                if (beat == 2'd3) begin
                    state_nxt = RD_TAIL;
                end
            end
            RD_TAIL: state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp        <= ADDR_W'(SP_INIT);
            base      <= '0;
            data      <= '0;
            rbuf      <= '0;
            beat      <= '0;
            gnt_stk   <= 1'b0;
            op_wr     <= 1'b0;
            err       <= 1'b0;
            last_stk  <= 1'b0;
            ls_rdata  <= '0;
            stk_rdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ls_req || stk_req) begin
                        gnt_stk <= pick_stk;
                        err     <= 1'b0;
                        beat    <= '0;
                        if (ls_req && stk_req) begin
                            last_stk <= pick_stk;
                        end
                        if (pick_stk) begin
                            op_wr <= ~stk_pop;
                            data  <= stk_wdata;
                            base  <= stk_pop ? sp : sp - ADDR_W'(4);
                        end else begin
                            op_wr <= ls_we;
                            data  <= ls_wdata;
                            base  <= ls_addr[ADDR_W-1:0];
                        end
                    end
                end
                CHECK: begin
                    err  <= fault;
                    beat <= '0;
                end
                WR: beat <= beat + 2'd1;
                RD: begin
                    beat <= beat + 2'd1;
                    // Memory answers one cycle late: beat k lands byte k-1.
                    unique case (beat)
                        2'd1:    rbuf[7:0]   <= mem_rdata;
                        2'd2:    rbuf[15:8]  <= mem_rdata;
                        2'd3:    rbuf[23:16] <= mem_rdata;
                        default: ;
                    endcase
                end
                RD_TAIL: begin
                    if (gnt_stk) begin
                        stk_rdata <= {mem_rdata, rbuf};
                    end else begin
                        ls_rdata <= {mem_rdata, rbuf};
                    end
                end
                DONE: begin
                    if (gnt_stk && !err) begin
                        sp <= op_wr ? sp - ADDR_W'(4) : sp + ADDR_W'(4);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = 8'h00;
        if (state == WR || state == RD) begin
            mem_addr = base + ADDR_W'(beat);
        end
        if (state == WR) begin
            mem_wdata = data[{beat, 3'b000} +: 8];
        end
    end

    assign mem_we   = (state == WR);
    assign mem_re   = (state == RD);
    assign busy     = (state != IDLE);
    assign sp_out   = sp;
    assign ls_done  = (state == DONE) & ~gnt_stk;
    assign stk_done = (state == DONE) & gnt_stk;
    assign stk_err  = stk_done & err;

`ifdef MISALIGN_TRAP_EN
    assign ls_err = ls_done & err;
`else
    assign ls_err = 1'b0;
`endif

endmodule

// File: tb/tb_stack_mem_ctrl.sv
// Directed self-checking bench for stack_mem_ctrl with a byte-wide memory model.
// Honours MISALIGN_TRAP_EN the same way the design does.
module tb_stack_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        ls_req, ls_we, ls_done, ls_err;
    logic [31:0] ls_addr, ls_wdata, ls_rdata;
    logic        stk_req, stk_pop, stk_done, stk_err;
    logic [31:0] stk_wdata, stk_rdata;
    logic [9:0]  sp_out, mem_addr;
    logic        busy, mem_we, mem_re;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;

    logic [7:0]  mem [1024] = '{default: 8'h00};
    logic [17:0] wlog [$];
    int          we_cnt = 0;
    int          re_cnt = 0;
    int          viol = 0;

    int checks = 0;
    int errors = 0;

    stack_mem_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_done   (ls_done),
        .ls_rdata  (ls_rdata),
        .ls_err    (ls_err),
        .stk_req   (stk_req),
        .stk_pop   (stk_pop),
        .stk_wdata (stk_wdata),
        .stk_done  (stk_done),
        .stk_rdata (stk_rdata),
        .stk_err   (stk_err),
        .sp_out    (sp_out),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            wlog.push_back({mem_addr, mem_wdata});
            we_cnt <= we_cnt + 1;
        end
        if (mem_re) begin
            mem_rdata <= mem[mem_addr];
            re_cnt <= re_cnt + 1;
        end
        if ((mem_we && mem_re) || (ls_done && stk_done)) begin
            viol <= viol + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_w(input string tag, input int b,
                           input logic [17:0] e0, input logic [17:0] e1,
                           input logic [17:0] e2, input logic [17:0] e3);
        check({tag, "_n"}, wlog.size() - b, 4);
        check({tag, "_b0"}, 32'(wlog[b]), 32'(e0));
        check({tag, "_b1"}, 32'(wlog[b+1]), 32'(e1));
        check({tag, "_b2"}, 32'(wlog[b+2]), 32'(e2));
        check({tag, "_b3"}, 32'(wlog[b+3]), 32'(e3));
    endtask

    // op = stk_pop for stack requests, ls_we for load/store requests.
    task automatic run_req(input logic stk, input logic op,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output int lat, output logic [31:0] rd,
                           output logic er);
        @(negedge clk);
        if (stk) begin
            stk_req = 1'b1; stk_pop = op; stk_wdata = wd;
        end else begin
            ls_req = 1'b1; ls_we = op; ls_addr = addr; ls_wdata = wd;
        end
        lat = 0; rd = '0; er = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (stk ? stk_done : ls_done) begin
                lat = n;
                rd = stk ? stk_rdata : ls_rdata;
                er = stk ? stk_err : ls_err;
                break;
            end
        end
        stk_req = 1'b0;
        ls_req = 1'b0;
    endtask

    task automatic run_tie(input logic lwe, input logic [31:0] la,
                           input logic [31:0] lwd, input logic pop,
                           input logic [31:0] swd,
                           output int slat, output int llat);
        @(negedge clk);
        ls_req = 1'b1; ls_we = lwe; ls_addr = la; ls_wdata = lwd;
        stk_req = 1'b1; stk_pop = pop; stk_wdata = swd;
        slat = 0; llat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (stk_done) begin slat = n; stk_req = 1'b0; end
            if (ls_done) begin llat = n; ls_req = 1'b0; end
            if (slat != 0 && llat != 0) break;
        end
        stk_req = 1'b0;
        ls_req = 1'b0;
    endtask

    int          lat, slat, llat, wb, wc, rc;
    logic [31:0] rd;
    logic        er;

    initial begin
        reset = 1'b1;
        ls_req = 0; ls_we = 0; ls_addr = '0; ls_wdata = '0;
        stk_req = 0; stk_pop = 0; stk_wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_sp", sp_out, 1023);
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_sp", sp_out, 1023);
        check("idle_strobe", {mem_we, mem_re}, 0);
        check("idle_addr", mem_addr, 0);
        check("idle_wdata", mem_wdata, 0);
        check("idle_done", {ls_done, stk_done, ls_err, stk_err}, 0);
        check("idle_ls_rdata", ls_rdata, 0);
        check("idle_stk_rdata", stk_rdata, 0);

        wb = wlog.size();
        run_req(1, 0, 0, 32'hDEADBEEF, lat, rd, er);
        check("push_lat", lat, 6);
        check("push_err", er, 0);
        check_w("push_wr", wb, {10'd1019, 8'hEF}, {10'd1020, 8'hBE},
                {10'd1021, 8'hAD}, {10'd1022, 8'hDE});
        @(negedge clk);
        check("push_sp", sp_out, 1019);

        run_req(1, 1, 0, 0, lat, rd, er);
        check("pop_lat", lat, 7);
        check("pop_data", rd, 32'hDEADBEEF);
        check("pop_err", er, 0);
        @(negedge clk);
        check("pop_sp", sp_out, 1023);

        wc = we_cnt; rc = re_cnt;
        run_req(1, 1, 0, 0, lat, rd, er);
        check("unf_lat", lat, 2);
        check("unf_err", er, 1);
        @(negedge clk);
        check("unf_sp", sp_out, 1023);
        check("unf_we", we_cnt - wc, 0);
        check("unf_re", re_cnt - rc, 0);

        run_tie(1, 32'h100, 32'hCAFEF00D, 0, 32'h01020304, slat, llat);
        check("tie1_stk_lat", slat, 6);
        check("tie1_ls_lat", llat, 13);
        @(negedge clk);
        check("tie1_sp", sp_out, 1019);
        check("tie1_mem", {mem[259], mem[258], mem[257], mem[256]},
              32'hCAFEF00D);

        run_tie(0, 32'h100, 0, 1, 0, slat, llat);
        check("tie2_ls_lat", llat, 7);
        check("tie2_stk_lat", slat, 15);
        check("tie2_ls_data", ls_rdata, 32'hCAFEF00D);
        check("tie2_stk_data", stk_rdata, 32'h01020304);
        @(negedge clk);
        check("tie2_sp", sp_out, 1023);

        wb = wlog.size();
        run_req(0, 1, 32'hABCD_07FE, 32'h11223344, lat, rd, er);
`ifdef MISALIGN_TRAP_EN
        check("sw_wrap_lat", lat, 2);
        check("sw_wrap_err", er, 1);
        check("sw_wrap_nowr", wlog.size() - wb, 0);
        run_req(0, 0, 32'h0000_03FE, 0, lat, rd, er);
        check("lw_wrap_lat", lat, 2);
        check("lw_wrap_err", er, 1);
`else
        check("sw_wrap_lat", lat, 6);
        check("sw_wrap_err", er, 0);
        check_w("sw_wrap", wb, {10'd1022, 8'h44}, {10'd1023, 8'h33},
                {10'd0, 8'h22}, {10'd1, 8'h11});
        run_req(0, 0, 32'h0000_03FE, 0, lat, rd, er);
        check("lw_wrap_lat", lat, 7);
        check("lw_wrap_data", rd, 32'h11223344);
        check("lw_wrap_err", er, 0);
`endif

        run_req(1, 0, 0, 32'h0, lat, rd, er);
        @(negedge clk);
        check("pre_rst_sp", sp_out, 1019);
        @(negedge clk);
        ls_req = 1; ls_we = 1; ls_addr = 32'h200; ls_wdata = 32'hA1B2C3D4;
        repeat (4) @(negedge clk);
        check("beat2_we", mem_we, 1);
        check("beat2_addr", mem_addr, 10'h202);
        check("beat2_wdata", mem_wdata, 8'hB2);
        reset = 1'b1;
        ls_req = 1'b0;
        #1;
        check("rst_mid_we", mem_we, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_sp", sp_out, 1023);
        @(negedge clk);
        check("rst_mid_done", {ls_done, stk_done}, 0);
        reset = 1'b0;
        check("rst_mid_mem",
              {mem[515], mem[514], mem[513], mem[512]}, 32'h0000C3D4);
        run_req(1, 0, 0, 32'h55667788, lat, rd, er);
        check("post_rst_lat", lat, 6);
        @(negedge clk);
        check("post_rst_sp", sp_out, 1019);
        check("post_rst_mem", {mem[1022], mem[1021], mem[1020], mem[1019]},
              32'h55667788);

        check("strobe_excl", viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stack_mem_ctrl.md
Name: stack_mem_ctrl

Overview:
Sequencer and arbiter in front of the byte-wide 1 KiB data memory. Shares the memory between the load/store requester (LW/SW) and the stack requester (PUSH/POP). Owns the stack pointer. Splits every 32-bit access into four byte beats, little-endian.

Parameters:
ADDR_W, 10, memory byte-address width (1024 bytes)
SP_INIT, 1023, stack pointer value after reset (stack empty)
STACK_BASE, 768, lowest byte address the stack may occupy

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
ls_req  in  1  load/store request; held until ls_done
ls_we  in  1  1 = store word, 0 = load word
ls_addr  in  32  byte address; only [ADDR_W-1:0] used
ls_wdata  in  32  store data
ls_done  out  1  one-cycle completion pulse
ls_rdata  out  32  load result; valid from the ls_done cycle until the next load completes
ls_err  out  1  misalignment error, qualified by ls_done (MISALIGN_TRAP_EN only, else tied 0)
stk_req  in  1  stack request; held until stk_done
stk_pop  in  1  1 = POP, 0 = PUSH
stk_wdata  in  32  push data
stk_done  out  1  one-cycle completion pulse
stk_rdata  out  32  pop result; valid from the stk_done cycle until the next pop completes
stk_err  out  1  overflow/underflow, qualified by stk_done
sp_out  out  ADDR_W  current stack pointer
busy  out  1  high in every state except IDLE
mem_addr  out  ADDR_W  byte address to memory
mem_we  out  1  byte write strobe
mem_wdata  out  8  byte write data
mem_re  out  1  byte read strobe; mem_rdata returned one cycle later
mem_rdata  in  8  byte read data

Behaviour:
- Reset values:
  - State IDLE, sp = SP_INIT.
  - All done, err and strobe outputs 0; mem_addr 0, mem_wdata 0.
  - ls_rdata and stk_rdata 0.
  - Round-robin pointer last = LS, so the stack wins the first tie.
- States: IDLE, CHECK, WR, RD, RD_TAIL, DONE.
- IDLE:
  - Requests are sampled only here.
  - One request pending: grant it.
  - Both pending: grant the requester that was not granted last; update last.
  - On grant, latch the op, the 32-bit data and the base address; go to CHECK.
- Base address:
  - Load/store: ls_addr[ADDR_W-1:0].
  - PUSH: sp - 4.
  - POP: sp.
- CHECK (1 cycle):
  - PUSH is an overflow if sp - 4 < STACK_BASE.
  - POP is an underflow if sp + 4 > SP_INIT.
  - On error: set the err flag and go to DONE. No memory access, sp unchanged.
  - Otherwise go to WR for SW/PUSH, or RD for LW/POP.
- WR (4 cycles, beat k = 0..3):
  - mem_we = 1, mem_addr = base + k, mem_wdata = data[8k+7:8k].
  - After beat 3, go to DONE.
- RD (4 cycles, beat k = 0..3):
  - mem_re = 1, mem_addr = base + k.
  - The byte returned one cycle later is captured into bits [8k+7:8k].
- RD_TAIL (1 cycle): captures byte 3; go to DONE.
- DONE (1 cycle):
  - Pulse done for the granted requester only, with the err flag.
  - Present the assembled word on rdata.
  - Update sp: PUSH sets sp = sp - 4, POP sets sp = sp + 4; no change on error.
  - Always return to IDLE. The requester drops req in the cycle after done, otherwise the request is accepted again.
- Latency from the request-sampled cycle T0:
  - Store/push: done at T6.
  - Load/pop: done at T7.
  - Error: done at T2.
- Address arithmetic:
  - base + k is modulo 2^ADDR_W; address 1022 wraps to bytes 1022, 1023, 0, 1.
  - The upper bits of ls_addr are ignored.
- LS accesses are not restricted from the stack region; software owns that.
- Never more than one strobe active per cycle; mem_we and mem_re are mutually exclusive.
- Reset mid-transaction:
  - Abort immediately; no further beats issue. Bytes already written stay in memory.
  - sp returns to SP_INIT; no done is issued.
- A req with no transaction in progress is ignored outside IDLE.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined:
  - CHECK also flags an LS access with ls_addr[1:0] != 0.
  - It goes to DONE with ls_err = 1 and no memory access.
- Undefined:
  - Unaligned LS accesses proceed byte-wise with wrap-around.
  - ls_err is constant 0.

Test Plan:
- PUSH 0xDEADBEEF after reset:
  - Beats write EF, BE, AD, DE to 1019..1022.
  - stk_done at T6; sp_out = 1019.
- POP immediately after:
  - stk_rdata = 0xDEADBEEF at T7; sp_out = 1023.
- POP on an empty stack:
  - stk_done at T2 with stk_err = 1; sp_out stays 1023; no mem_re/mem_we seen.
- ls_req and stk_req (PUSH) asserted together, both held:
  - Stack served first, then LS.
  - Second pair of simultaneous requests: served in the order LS, then stack.
- SW 0x11223344 at address 1022, then LW 1022:
  - Bytes 44, 33, 22, 11 land at 1022, 1023, 0, 1.
  - ls_rdata = 0x11223344.
  - With MISALIGN_TRAP_EN defined, the SW instead returns ls_err = 1 and causes no write.
- Reset asserted during beat 2 of a store:
  - mem_we drops the same cycle; sp = 1023; the next request starts cleanly from IDLE.
